ahb_qos_arbiter: RTL and testbench

- Priority/QoS arbiter for the shared AHB bus; alternative to the round-robin arbiter for systems with latency-critical masters.
- Selects the address-phase owner from per-master static priorities, with aging to prevent starvation.
- Honours fixed-length bursts, INCR bursts and locked sequences.
- Tracks address-phase and data-phase master indices so the master mux and the decoder can steer correctly.

---
 rtl/ahb_arb_pkg.sv | 43 ++++
 rtl/ahb_arb_select.sv | 50 +++++
 rtl/ahb_qos_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ahb_qos_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB priority/QoS arbiter.
// NUM_MASTERS_DFLT is the default master count; override via the NUM_MASTERS parameter.
package ahb_arb_pkg;

    localparam int NUM_MASTERS_DFLT = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        PARK,
        OWN,
        BFIX,
        BINCR,
        LOCK
    } arb_state_e;

    // Beat count of a burst; 0 marks the open-ended INCR.
    function automatic logic [4:0] burst_len(input hburst_e burst);
        case (burst)
            HBURST_SINGLE:                return 5'd1;
            HBURST_INCR:                  return 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arb_select.sv
// Combinational winner picker: aged requesters first, then highest priority;
// lowest index breaks ties, DEFAULT_MASTER when nobody requests.
module ahb_arb_select
    import ahb_arb_pkg::*;
#(
    parameter int  NUM_MASTERS    = 4,
    parameter int  PRIO_W         = 2,
    parameter int  DEFAULT_MASTER = 0,
    localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS*PRIO_W-1:0] prio,
    input  logic [NUM_MASTERS-1:0]        aged,
    output logic [IDX_W-1:0]              winner
);

    logic              have_aged;
    logic              have_req;
    logic [IDX_W-1:0]  aged_idx;
    logic [IDX_W-1:0]  prio_idx;
    logic [PRIO_W-1:0] best_prio;

    // NOTE: blocking assignments here model a priority scan; every variable gets a default first, so no latch.
    always_comb begin
        have_aged = 1'b0;
        have_req  = 1'b0;
        aged_idx  = '0;
        prio_idx  = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req[i] && aged[i] && !have_aged) begin
                have_aged = 1'b1;
                aged_idx  = IDX_W'(i);
            end
            // Strict '>' keeps the lowest index on equal priority.
            if (req[i] && (!have_req || prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                have_req  = 1'b1;
                best_prio = prio[i*PRIO_W +: PRIO_W];
                prio_idx  = IDX_W'(i);
            end
        end
        if (have_aged)
            winner = aged_idx;
        else if (have_req)
            winner = prio_idx;
        else
            winner = IDX_W'(DEFAULT_MASTER);
    end

endmodule

// File: rtl/ahb_qos_arbiter.sv
// AHB priority/QoS arbiter with aging, burst/lock awareness and owner tracking.
// Defining AHB_ARB_TENURE_EN caps INCR bursts at TENURE_MAX beats when others wait.
module ahb_qos_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int  NUM_MASTERS    = NUM_MASTERS_DFLT,
    parameter int  PRIO_W         = 2,
    parameter int  AGE_W          = 4,
    parameter int  AGE_LIMIT      = 15,
    parameter int  DEFAULT_MASTER = 0,
`ifdef AHB_ARB_TENURE_EN
    parameter int  TENURE_MAX     = 16,
`endif
    localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          Hclk,
    input  logic                          Hresetn,
    input  logic [NUM_MASTERS-1:0]        Hreq,
    input  logic [NUM_MASTERS-1:0]        Hlock,
    input  logic [NUM_MASTERS*PRIO_W-1:0] Hprio,
    input  logic                          Hready,
    input  logic [1:0]                    Htrans,
    input  logic [2:0]                    Hburst,
    output logic [NUM_MASTERS-1:0]        Hgrant,
    output logic [IDX_W-1:0]              Hmaster,
    output logic [IDX_W-1:0]              Hmaster_data,
    output logic                          Hmastlock
);

    arb_state_e             state, state_nxt;
    logic [3:0]             beats_left, beats_nxt;
    logic [AGE_W-1:0]       age [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] aged;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       grant_idx;
    logic                   rearb;
    logic                   tenure_hit;
    logic                   is_idle, is_nonseq, is_seq;
    logic [4:0]             blen;

    assign is_idle   = (Htrans == HTRANS_IDLE);
    assign is_nonseq = (Htrans == HTRANS_NONSEQ);
    assign is_seq    = (Htrans == HTRANS_SEQ);
    assign blen      = burst_len(hburst_e'(Hburst));

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++)
            aged[i] = (age[i] == AGE_W'(AGE_LIMIT));
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (Hgrant[i]) grant_idx = IDX_W'(i);
    end

    ahb_arb_select #(
        .NUM_MASTERS    (NUM_MASTERS),
        .PRIO_W         (PRIO_W),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_select (
        .req    (Hreq),
        .prio   (Hprio),
        .aged   (aged),
        .winner (winner)
    );

`ifdef AHB_ARB_TENURE_EN
    localparam int TEN_W = $clog2(TENURE_MAX) + 1;
    logic [TEN_W-1:0] tenure_cnt;

    assign tenure_hit = is_seq && (tenure_cnt >= TEN_W'(TENURE_MAX - 1)) &&
                        |(Hreq & ~(NUM_MASTERS'(1) << Hmaster));

    // Held at zero outside BINCR, so it is clear on every entry.
    always_ff @(posedge Hclk) begin
        if (!Hresetn)
            tenure_cnt <= '0;
        else if (Hready) begin
            if (state != BINCR)
                tenure_cnt <= '0;
            else if (is_seq && tenure_cnt != TEN_W'(TENURE_MAX))
                tenure_cnt <= tenure_cnt + 1'b1;
        end
    end
`else
    assign tenure_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        beats_nxt = beats_left;
        rearb     = 1'b0;
        case (state)
            PARK: begin
                rearb = 1'b1;
                if (Hreq[grant_idx]) state_nxt = OWN;
            end
            OWN: begin
                if (is_nonseq && Hlock[Hmaster])
                    state_nxt = LOCK;
                else if (is_nonseq && blen == 5'd0)
                    state_nxt = BINCR;
                else if (is_nonseq && blen > 5'd1) begin
                    state_nxt = BFIX;
                    beats_nxt = 4'(blen - 5'd1);
                end else begin
                    rearb = 1'b1;
                    if (Hreq == '0) state_nxt = PARK;
                end
            end
            BFIX: begin
                if (is_idle || (is_seq && beats_left == 4'd1)) begin
                    rearb     = 1'b1;
                    state_nxt = OWN;
                    beats_nxt = '0;
                end else if (is_seq)
                    beats_nxt = beats_left - 1'b1;
            end
            BINCR: begin
                if (!Hreq[Hmaster] || is_idle || tenure_hit) begin
                    rearb     = 1'b1;
                    state_nxt = OWN;
                end
            end
            LOCK: begin
                if (!Hlock[Hmaster] && is_idle) state_nxt = OWN;
            end
            default: state_nxt = PARK;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state        <= PARK;
            beats_left   <= '0;
            Hgrant       <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            Hmaster      <= IDX_W'(DEFAULT_MASTER);
            Hmaster_data <= IDX_W'(DEFAULT_MASTER);
            Hmastlock    <= 1'b0;
        end else if (Hready) begin
            state        <= state_nxt;
            beats_left   <= beats_nxt;
            if (rearb) Hgrant <= NUM_MASTERS'(1) << winner;
            Hmaster      <= grant_idx;
            Hmaster_data <= Hmaster;
            Hmastlock    <= Hlock[grant_idx];
        end
    end

    // NOTE: the age array is a handful of flops feeding arbitration, so it is reset like any other state.
    // Ages keep counting through Hready stalls.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            for (int i = 0; i < NUM_MASTERS; i++)
                age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!Hreq[i] || Hmaster == IDX_W'(i))
                    age[i] <= '0;
                else if (!aged[i])
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_qos_arbiter.sv
// Directed bench for ahb_qos_arbiter: vector table plus lock/aging, reset and INCR tenure sequences.
module tb_ahb_qos_arbiter;
    import ahb_arb_pkg::*;

`ifdef AHB_ARB_TENURE_EN
    localparam bit TENURE_ON = 1'b1;
`else
    localparam bit TENURE_ON = 1'b0;
`endif

    logic       Hclk = 1'b0;
    logic       Hresetn;
    logic [3:0] Hreq;
    logic [3:0] Hlock;
    logic [7:0] Hprio;
    logic       Hready;
    logic [1:0] Htrans;
    logic [2:0] Hburst;
    logic [3:0] Hgrant;
    logic [1:0] Hmaster;
    logic [1:0] Hmaster_data;
    logic       Hmastlock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic       ready;
        logic [1:0] trans;
        logic [2:0] burst;
        logic [3:0] e_grant;
        logic [1:0] e_master;
        logic [1:0] e_mdata;
        logic       e_lock;
    } vec_t;

    vec_t vecs [20];

    ahb_qos_arbiter dut (
        .Hclk         (Hclk),
        .Hresetn      (Hresetn),
        .Hreq         (Hreq),
        .Hlock        (Hlock),
        .Hprio        (Hprio),
        .Hready       (Hready),
        .Htrans       (Htrans),
        .Hburst       (Hburst),
        .Hgrant       (Hgrant),
        .Hmaster      (Hmaster),
        .Hmaster_data (Hmaster_data),
        .Hmastlock    (Hmastlock)
    );

    always #5 Hclk = ~Hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] req, input logic ready, input logic [1:0] trans,
                                input logic [2:0] burst, input logic [3:0] g, input logic [1:0] m,
                                input logic [1:0] md, input logic lk);
        vec_t v;
        v.req = req; v.ready = ready; v.trans = trans; v.burst = burst;
        v.e_grant = g; v.e_master = m; v.e_mdata = md; v.e_lock = lk;
        return v;
    endfunction

    initial begin
        // Priority, INCR4 with BUSY and handover, Hready stall during ownership change.
        vecs[0]  = mk(4'b0110, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b0010, 2'd0, 2'd0, 1'b0);
        vecs[1]  = mk(4'b0110, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b0010, 2'd1, 2'd0, 1'b0);
        vecs[2]  = mk(4'b1110, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd1, 2'd1, 1'b0);
        vecs[3]  = mk(4'b1110, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd3, 2'd1, 1'b0);
        vecs[4]  = mk(4'b0110, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b0010, 2'd3, 2'd3, 1'b0);
        vecs[5]  = mk(4'b0110, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b0010, 2'd1, 2'd3, 1'b0);
        vecs[6]  = mk(4'b0110, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,  4'b0010, 2'd1, 2'd1, 1'b0);
        vecs[7]  = mk(4'b0100, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  4'b0010, 2'd1, 2'd1, 1'b0);
        vecs[8]  = mk(4'b0100, 1'b1, HTRANS_BUSY,   HBURST_INCR4,  4'b0010, 2'd1, 2'd1, 1'b0);
        vecs[9]  = mk(4'b0100, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  4'b0010, 2'd1, 2'd1, 1'b0);
        vecs[10] = mk(4'b0100, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  4'b0100, 2'd1, 2'd1, 1'b0);
        vecs[11] = mk(4'b0100, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b0100, 2'd2, 2'd1, 1'b0);
        vecs[12] = mk(4'b0100, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b0100, 2'd2, 2'd2, 1'b0);
        vecs[13] = mk(4'b1000, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd2, 2'd2, 1'b0);
        vecs[14] = mk(4'b1000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd2, 2'd2, 1'b0);
        vecs[15] = mk(4'b1000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd2, 2'd2, 1'b0);
        vecs[16] = mk(4'b1000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd2, 2'd2, 1'b0);
        vecs[17] = mk(4'b1000, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd3, 2'd2, 1'b0);
        vecs[18] = mk(4'b1000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd3, 2'd2, 1'b0);
        vecs[19] = mk(4'b1000, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd3, 2'd3, 1'b0);

        Hresetn = 1'b0;
        Hreq    = 4'b0000;
        Hlock   = 4'b0000;
        Hprio   = 8'hD4;        // M3=3, M2=1, M1=1, M0=0
        Hready  = 1'b1;
        Htrans  = HTRANS_IDLE;
        Hburst  = HBURST_SINGLE;
        step();
        step();
        check("reset grant",     Hgrant,            4'b0001);
        check("reset master",    4'(Hmaster),       4'd0);
        check("reset mdata",     4'(Hmaster_data),  4'd0);
        check("reset mastlock",  4'(Hmastlock),     4'd0);
        Hresetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            Hreq   = vecs[i].req;
            Hready = vecs[i].ready;
            Htrans = vecs[i].trans;
            Hburst = vecs[i].burst;
            step();
            check($sformatf("vec%0d grant", i),    Hgrant,           vecs[i].e_grant);
            check($sformatf("vec%0d master", i),   4'(Hmaster),      4'(vecs[i].e_master));
            check($sformatf("vec%0d mdata", i),    4'(Hmaster_data), 4'(vecs[i].e_mdata));
            check($sformatf("vec%0d mastlock", i), 4'(Hmastlock),    4'(vecs[i].e_lock));
        end

        // Locked sequence by M3 while low-priority M0 ages to saturation.
        Hready = 1'b1;
        Hreq   = 4'b1001;
        Hlock  = 4'b1000;
        Htrans = HTRANS_NONSEQ;
        Hburst = HBURST_SINGLE;
        step();
        check("lock enter grant",    Hgrant,         4'b1000);
        check("lock enter mastlock", 4'(Hmastlock),  4'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("lock hold%0d grant", k),    Hgrant,        4'b1000);
            check($sformatf("lock hold%0d master", k),   4'(Hmaster),   4'd3);
            check($sformatf("lock hold%0d mastlock", k), 4'(Hmastlock), 4'd1);
        end
        Hlock  = 4'b0000;
        Htrans = HTRANS_IDLE;
        step();
        check("lock exit grant",    Hgrant,        4'b1000);
        check("lock exit mastlock", 4'(Hmastlock), 4'd0);
        step();
        check("aged M0 wins grant", Hgrant,        4'b0001);
        step();
        check("aged M0 master",     4'(Hmaster),   4'd0);

        // Synchronous reset in the middle of an INCR8 with Hmastlock high.
        Hreq = 4'b1000;
        step();
        step();
        Htrans = HTRANS_NONSEQ;
        Hburst = HBURST_INCR8;
        step();
        Htrans = HTRANS_SEQ;
        Hlock  = 4'b1000;
        step();
        check("pre-reset grant",    Hgrant,        4'b1000);
        check("pre-reset master",   4'(Hmaster),   4'd3);
        check("pre-reset mastlock", 4'(Hmastlock), 4'd1);
        Hresetn = 1'b0;
        step();
        check("mid-burst reset grant",    Hgrant,           4'b0001);
        check("mid-burst reset master",   4'(Hmaster),      4'd0);
        check("mid-burst reset mdata",    4'(Hmaster_data), 4'd0);
        check("mid-burst reset mastlock", 4'(Hmastlock),    4'd0);
        step();
        Hresetn = 1'b1;
        Hlock   = 4'b0000;
        step();
        check("post-reset PARK rearbitrates", Hgrant, 4'b1000);

        // INCR burst of 30 beats by M2 while M1 waits.
        Hreq   = 4'b0100;
        Htrans = HTRANS_IDLE;
        Hburst = HBURST_SINGLE;
        step();
        step();
        check("incr owner master", 4'(Hmaster), 4'd2);
        check("incr owner grant",  Hgrant,      4'b0100);
        Hreq   = 4'b0110;
        Htrans = HTRANS_NONSEQ;
        Hburst = HBURST_INCR;
        step();
        check("incr start grant", Hgrant, 4'b0100);
        Htrans = HTRANS_SEQ;
        for (int k = 1; k <= 29; k++) begin
            step();
            check($sformatf("incr seq%0d grant", k), Hgrant,
                  (TENURE_ON && k >= 16) ? 4'b0010 : 4'b0100);
        end
        Htrans = HTRANS_IDLE;
        step();
        check("incr end grant",     Hgrant,      4'b0010);
        step();
        check("incr handover master", 4'(Hmaster), 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
